// File: rtl/ps2_kbd_responder_if.sv
// Byte-level link between the PS/2 device serializer and the keyboard command responder.
// master = serializer/host side, slave = responder.
interface ps2_kbd_responder_if;
  logic       busy;
  logic       read;
  logic [7:0] rx_data;
  logic       write;
  logic [7:0] tx_data;
  logic [2:0] leds;
  logic       cmd_err;

  modport master (
    output busy, read, rx_data,
    input  write, tx_data, leds, cmd_err
  );

  modport slave (
    input  busy, read, rx_data,
    output write, tx_data, leds, cmd_err
  );
endinterface

// File: rtl/ps2_kbd_responder.sv
// Device-side PS/2 keyboard command responder (reset, set-LED, echo, resend, optional read-ID).
// Define KBD_RESP_ID_EN to answer 0xF2 with FA AB 83; otherwise 0xF2 is rejected with 0xFE.
//
// state | meaning
// BAT   | self-test delay; counts once armed, then queues 0xAA
// IDLE  | decoding host command bytes
// ARG   | waiting for the 0xED LED argument byte
module ps2_kbd_responder #(
  parameter int unsigned BAT_CYCLES = 500000
) (
  input logic              clk,
  input logic              reset,
  ps2_kbd_responder_if.slave bus
);

`ifdef KBD_RESP_ID_EN
  localparam int QDEPTH = 3;
`else
  localparam int QDEPTH = 1;
`endif
  localparam int QW = QDEPTH * 8;
  localparam logic [19:0] BAT_LAST = 20'(BAT_CYCLES - 1);

  typedef enum logic [1:0] {ST_BAT, ST_IDLE, ST_ARG} state_t;

  state_t          state_q, state_d;
  logic [19:0]     bat_cnt_q, bat_cnt_d;
  logic            bat_run_q, bat_run_d;
  logic [QW-1:0]   fifo_q, fifo_d;
  logic [1:0]      count_q, count_d;
  logic            wr_prev_q, wr_prev_d;
  logic [7:0]      last_q, last_d;
  logic [7:0]      tx_hold_q, tx_hold_d;
  logic [2:0]      leds_q, leds_d;
  logic            cmd_err_q, cmd_err_d;

  logic            write_c;
  logic            do_decode;
  logic            ld;
  logic [QW-1:0]   ld_vec;
  logic [1:0]      ld_cnt;

  always_comb begin
    write_c   = (count_q != 2'd0) && !bus.busy && !bus.read && !wr_prev_q;
    state_d   = state_q;
    bat_cnt_d = bat_cnt_q;
    bat_run_d = bat_run_q;
    fifo_d    = fifo_q;
    count_d   = count_q;
    wr_prev_d = write_c;
    last_d    = last_q;
    tx_hold_d = tx_hold_q;
    leds_d    = leds_q;
    cmd_err_d = 1'b0;
    do_decode = 1'b0;
    ld        = 1'b0;
    ld_vec    = '0;
    ld_cnt    = 2'd0;

    if (write_c) begin
      fifo_d    = fifo_q >> 8;
      count_d   = count_q - 2'd1;
      last_d    = fifo_q[7:0];
      tx_hold_d = fifo_q[7:0];
      // In BAT the only byte that can go out is the 0xFF ack; its issue arms the timer.
      if (state_q == ST_BAT) begin
        bat_run_d = 1'b1;
        bat_cnt_d = '0;
      end
    end

    case (state_q)
      ST_BAT: begin
        if (bus.read && bus.rx_data == 8'hFF) begin
          do_decode = 1'b1;
        end else if (bat_run_q) begin
          if (bat_cnt_q == BAT_LAST) begin
            ld        = 1'b1;
            ld_vec    = QW'(8'hAA);
            ld_cnt    = 2'd1;
            bat_run_d = 1'b0;
            bat_cnt_d = '0;
            state_d   = ST_IDLE;
          end else begin
            bat_cnt_d = bat_cnt_q + 20'd1;
          end
        end
      end
      ST_IDLE: begin
        if (bus.read) do_decode = 1'b1;
      end
      ST_ARG: begin
        if (bus.read) begin
          if (bus.rx_data < 8'hED) begin
            leds_d  = bus.rx_data[2:0];
            ld      = 1'b1;
            ld_vec  = QW'(8'hFA);
            ld_cnt  = 2'd1;
            state_d = ST_IDLE;
          end else begin
            do_decode = 1'b1;
          end
        end
      end
      default: state_d = ST_BAT;
    endcase

    if (do_decode) begin
      state_d = ST_IDLE;
      ld      = 1'b1;
      ld_cnt  = 2'd1;
      case (bus.rx_data)
        8'hFF: begin
          ld_vec    = QW'(8'hFA);
          leds_d    = 3'b000;
          state_d   = ST_BAT;
          bat_run_d = 1'b0;
          bat_cnt_d = '0;
        end
        8'hED: begin
          ld_vec  = QW'(8'hFA);
          state_d = ST_ARG;
        end
        8'hEE: ld_vec = QW'(8'hEE);
        8'hFE: ld_vec = QW'(last_q);
`ifdef KBD_RESP_ID_EN
        8'hF2: begin
          ld_vec = {8'h83, 8'hAB, 8'hFA};
          ld_cnt = 2'd3;
        end
`endif
        default: begin
          ld_vec    = QW'(8'hFE);
          cmd_err_d = 1'b1;
        end
      endcase
    end

    // A new command replaces whatever was still waiting to be sent.
    if (ld) begin
      fifo_d  = ld_vec;
      count_d = ld_cnt;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_BAT;
      bat_cnt_q <= '0;
      bat_run_q <= 1'b1;
      fifo_q    <= '0;
      count_q   <= 2'd0;
      wr_prev_q <= 1'b0;
      last_q    <= 8'hAA;
      tx_hold_q <= 8'h00;
      leds_q    <= 3'b000;
      cmd_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      bat_cnt_q <= bat_cnt_d;
      bat_run_q <= bat_run_d;
      fifo_q    <= fifo_d;
      count_q   <= count_d;
      wr_prev_q <= wr_prev_d;
      last_q    <= last_d;
      tx_hold_q <= tx_hold_d;
      leds_q    <= leds_d;
      cmd_err_q <= cmd_err_d;
    end
  end

  // tx_data shows the head during the write cycle and holds it until the next write.
  assign bus.write   = write_c;
  assign bus.tx_data = write_c ? fifo_q[7:0] : tx_hold_q;
  assign bus.leds    = leds_q;
  assign bus.cmd_err = cmd_err_q;

endmodule

// File: doc/ps2_kbd_responder.md
# ps2_kbd_responder

Device-side PS/2 keyboard command responder: the keyboard end of the host link that issues reset (0xFF) and set-LED (0xED + argument) commands and waits for 0xFA acknowledges. It sits behind a byte-level PS/2 device serializer and consumes received host bytes (`read`/`rx_data`). It emits reply bytes (`write`/`tx_data`, gated by `busy`) and drives the three lock-LED outputs. It is used as a keyboard model on the board and as a loop-back target for the host-side controller.

## Interface
- `BAT_CYCLES`, default 500000: clock cycles from reset deassertion, or from a 0xFF command's ack being issued, to the 0xAA self-test-passed byte; legal range 1 to 2^20-1.
- `clk` input 1: system clock; all logic on the rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `busy` input 1: serializer is transmitting; no `write` may be issued while high.
- `read` input 1: one-cycle strobe; `rx_data` holds a received host byte.
- `rx_data` input 8: received host byte, valid when `read`=1.
- `write` output 1: one-cycle strobe requesting transmission of `tx_data`.
- `tx_data` output 8: reply byte; held stable from `write` until the next `write`.
- `leds` output 3: bit2 Caps, bit1 Num, bit0 Scroll; these are the low three bits of the last accepted 0xED argument.
- `cmd_err` output 1: one-cycle pulse when an unsupported command byte is received.

## Operation
- Reply queue: 3-byte FIFO with a 2-bit count. Commands load the queue atomically; any prior content is flushed.
- Control FSM states:
  - BAT: count `BAT_CYCLES`, then enqueue 0xAA, go IDLE. Entered at reset release and after 0xFF.
  - IDLE: decode each `read` byte:
    - 0xFF: enqueue 0xFA, clear `leds`, go BAT. The counter starts when 0xFA's `write` issues.
    - 0xED: enqueue 0xFA, go ARG.
    - 0xEE: enqueue 0xEE (echo, no ack).
    - 0xFE: enqueue the last byte transmitted; 0xAA if nothing has been sent since reset.
    - 0xF2: see Configuration.
    - Anything else: enqueue 0xFE, pulse `cmd_err`.
  - ARG:
    - A byte below 0xED: latch `leds` <= byte[2:0], enqueue 0xFA, go IDLE.
    - A byte of 0xED or above: abandon the argument, leave `leds` unchanged, decode the byte as in IDLE.
- Bytes received while in BAT are ignored, except 0xFF, which restarts BAT.
- Transmit rule: `write`=1 when the queue is non-empty, `busy`=0, `read`=0, and `write` was 0 in the previous cycle. `tx_data` is the queue head; the head pops on the same edge. The last-sent register updates on the same edge.
- `read` and an eligible `write` in the same cycle: `read` wins. `write` is suppressed and the queue is replaced per the decode.
- Queue overflow cannot occur: the largest load is 3 bytes and every load flushes.

## Timing
- Reset values: `write`=0, `tx_data`=0x00, `leds`=3'b000, `cmd_err`=0, queue empty, FSM=BAT, BAT counter=0, last-sent=0xAA.
- First 0xAA `write` occurs `BAT_CYCLES`+1 cycles after `reset` rises, provided `busy`=0.
- Latency: `read` in cycle N leads to the first reply `write` in cycle N+1 at the earliest. Consecutive queued bytes are separated by at least 2 cycles and wait for `busy`=0.
- `leds` updates in the cycle after the argument byte's `read`. `cmd_err` pulses in the cycle after `read`.
- Reset asserted mid-operation: all state returns to reset values immediately; no further `write` until BAT completes.

## Configuration
- `KBD_RESP_ID_EN` defined: 0xF2 (read ID) enqueues 0xFA, 0xAB, 0x83, all three bytes in order.
- `KBD_RESP_ID_EN` undefined: 0xF2 is an unsupported command. It enqueues 0xFE and pulses `cmd_err`. The queue is then 1 byte deep.

## Test plan
- Power-up with `BAT_CYCLES`=20 and `busy`=0: no `write` for 20 cycles after `reset` rises, then exactly one `write` with `tx_data`=0xAA.
- 0xED then 0x04: `tx_data` 0xFA, then 0xFA; `leds`=3'b100. Next, 0xED then 0x03: `leds`=3'b011.
- 0xED then 0xEE: exactly one 0xFA followed by 0xEE; `leds` unchanged.
- 0xFF with `busy` held high for 10 cycles: the 0xFA `write` is delayed until `busy` falls; `leds`=0; 0xAA follows after `BAT_CYCLES`. Then 0xFE: 0xAA is re-sent.
- With `KBD_RESP_ID_EN` defined, 0xF2 yields 0xFA, 0xAB, 0x83, each `write` gated by `busy` pulses. With the macro undefined, 0xF2 yields 0xFE and one `cmd_err` pulse. 0x12 yields 0xFE in both builds.
- 0xF2 followed by 0xEE arriving after the first `write`: the remaining ID bytes are flushed and only 0xEE is sent. Async `reset` pulsed mid-queue: `write`=0 immediately and the queue is empty.
